// File: rtl/ex_mc_unit.sv
// ex_mc_unit: execute-stage ALU with an iterative unsigned divider.
//   Single-cycle ops (logic, add/sub, compares, shifts) register their result
//   the edge they are accepted. DIVU/REMU with a non-zero divisor run a
//   DATA_W-step restoring divider (IDLE -> DIV -> DONE) and then load the
//   same output register.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   valid_i/ready_o   upstream handshake (ready_o is combinational)
//   aluop_i           4-bit operation code
//   reg1_i, reg2_i    operands
//   wd_i, wreg_i      destination address / write enable, carried through
//   valid_o/ready_i   downstream handshake
//   wd_o, wreg_o      registered destination fields
//   wdata_o           registered result
//   busy_o            high while a divide is in flight (DIV or DONE)
module ex_mc_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned SH_W    = $clog2(DATA_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [3:0]         aluop_i,
  input  logic [DATA_W-1:0]  reg1_i,
  input  logic [DATA_W-1:0]  reg2_i,
  input  logic [RADDR_W-1:0] wd_i,
  input  logic               wreg_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [RADDR_W-1:0] wd_o,
  output logic               wreg_o,
  output logic [DATA_W-1:0]  wdata_o,
  output logic               busy_o
);

  localparam logic [3:0] OP_OR   = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_NOR  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_REMU = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   quot_q;
  logic [DATA_W-1:0]   rem_q;
  logic [DATA_W-1:0]   dvsr_q;
  logic [SH_W-1:0]     cnt_q;
  logic                is_rem_q;
  logic [RADDR_W-1:0]  wd_q;
  logic                wreg_q;

  logic [DATA_W-1:0]   alu_res;
  logic [SH_W-1:0]     shamt;
  logic                out_free;
  logic                accept;
  logic                is_div_op;
  logic                div_start;
  logic [DATA_W:0]     rem_sh;
  logic [DATA_W:0]     rem_diff;

  // Output slot can take a new value if empty or being drained this cycle.
  assign out_free  = !valid_o || ready_i;
  assign ready_o   = (state == S_IDLE) && out_free;
  assign accept    = valid_i && ready_o;
  assign is_div_op = (aluop_i == OP_DIVU) || (aluop_i == OP_REMU);
  assign div_start = accept && is_div_op && (reg2_i != '0);
  assign busy_o    = (state != S_IDLE);

  // Single-cycle result; divide-by-zero results are also produced here.
  always_comb begin
    alu_res = '0;
    shamt   = reg2_i[SH_W-1:0];
    case (aluop_i)
      OP_OR:   alu_res = reg1_i | reg2_i;
      OP_AND:  alu_res = reg1_i & reg2_i;
      OP_XOR:  alu_res = reg1_i ^ reg2_i;
      OP_NOR:  alu_res = ~(reg1_i | reg2_i);
      OP_ADD:  alu_res = reg1_i + reg2_i;
      OP_SUB:  alu_res = reg1_i - reg2_i;
      OP_SLT:  alu_res = DATA_W'($signed(reg1_i) < $signed(reg2_i));
      OP_SLTU: alu_res = DATA_W'(reg1_i < reg2_i);
      OP_SLL:  alu_res = reg1_i << shamt;
      OP_SRL:  alu_res = reg1_i >> shamt;
      OP_SRA:  alu_res = DATA_W'($signed(reg1_i) >>> shamt);
      OP_DIVU: alu_res = '1;
      OP_REMU: alu_res = reg1_i;
      default: alu_res = '0;
    endcase
  end

  // One restoring step: shift next dividend bit into the partial remainder
  // and subtract the divisor; a borrow (MSB set) means restore.
  always_comb begin
    rem_sh   = {rem_q, quot_q[DATA_W-1]};
    rem_diff = rem_sh - {1'b0, dvsr_q};
  end

  // Control FSM, divider datapath and registered output slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      quot_q   <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      cnt_q    <= '0;
      is_rem_q <= 1'b0;
      wd_q     <= '0;
      wreg_q   <= 1'b0;
      valid_o  <= 1'b0;
      wd_o     <= '0;
      wreg_o   <= 1'b0;
      wdata_o  <= '0;
    end else begin
      // Drain; a same-cycle load below overrides this without a bubble.
      if (valid_o && ready_i) valid_o <= 1'b0;

      case (state)
        S_IDLE: begin
          if (div_start) begin
            state    <= S_DIV;
            quot_q   <= reg1_i;
            rem_q    <= '0;
            dvsr_q   <= reg2_i;
            cnt_q    <= '0;
            is_rem_q <= (aluop_i == OP_REMU);
            wd_q     <= wd_i;
            wreg_q   <= wreg_i;
          end else if (accept) begin
            valid_o <= 1'b1;
            wdata_o <= alu_res;
            wd_o    <= wd_i;
            wreg_o  <= wreg_i;
          end
        end
        S_DIV: begin
          if (!rem_diff[DATA_W]) begin
            rem_q  <= rem_diff[DATA_W-1:0];
            quot_q <= {quot_q[DATA_W-2:0], 1'b1};
          end else begin
            rem_q  <= rem_sh[DATA_W-1:0];
            quot_q <= {quot_q[DATA_W-2:0], 1'b0};
          end
          cnt_q <= cnt_q + SH_W'(1);
          if (cnt_q == SH_W'(DATA_W - 1)) state <= S_DONE;
        end
        S_DONE: begin
          if (out_free) begin
            valid_o <= 1'b1;
            wdata_o <= is_rem_q ? rem_q : quot_q;
            wd_o    <= wd_q;
            wreg_o  <= wreg_q;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mc_unit.sv
// Testbench for ex_mc_unit: directed cases plus randomized traffic, with a
// scoreboard fed at acceptance and drained by an independent output monitor.
module tb_ex_mc_unit;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_i;
  logic          ready_o;
  logic [3:0]    aluop_i;
  logic [DW-1:0] reg1_i;
  logic [DW-1:0] reg2_i;
  logic [AW-1:0] wd_i;
  logic          wreg_i;
  logic          valid_o;
  logic          ready_i;
  logic [AW-1:0] wd_o;
  logic          wreg_o;
  logic [DW-1:0] wdata_o;
  logic          busy_o;

  typedef struct packed {
    logic [AW-1:0] wd;
    logic          wreg;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;
  bit   rdy_rand   = 1'b0;
  bit   rdy_force  = 1'b1;

  ex_mc_unit #(.DATA_W(DW), .RADDR_W(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .aluop_i (aluop_i),
    .reg1_i  (reg1_i),
    .reg2_i  (reg2_i),
    .wd_i    (wd_i),
    .wreg_i  (wreg_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .wd_o    (wd_o),
    .wreg_o  (wreg_o),
    .wdata_o (wdata_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  // Downstream ready, changed only at falling edges.
  always @(negedge clk) ready_i = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference behaviour straight from the opcode table.
  function automatic logic [DW-1:0] model(input logic [3:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      4'd0:  return a | b;
      4'd1:  return a & b;
      4'd2:  return a ^ b;
      4'd3:  return ~(a | b);
      4'd4:  return a + b;
      4'd5:  return a - b;
      4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:  return (a < b) ? 32'd1 : 32'd0;
      4'd8:  return a << sh;
      4'd9:  return a >> sh;
      4'd10: return a[DW-1] ? ~((~a) >> sh) : (a >> sh);
      4'd11: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd12: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Output monitor: pops the scoreboard on every transfer and checks that a
  // stalled result does not change.
  logic [DW+AW+1:0] prev;
  bit               have_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev)
        check("hold_stable", 64'({valid_o, wd_o, wreg_o, wdata_o}), 64'(prev));
      if (valid_o && ready_i) begin
        have_prev = 1'b0;
        if (sb.size() == 0) begin
          check("spurious_output", 64'(valid_o), 64'(0));
        end else begin
          e = sb.pop_front();
          check("result", 64'({wd_o, wreg_o, wdata_o}), 64'(e));
        end
      end else if (valid_o) begin
        have_prev = 1'b1;
        prev = {valid_o, wd_o, wreg_o, wdata_o};
      end else begin
        have_prev = 1'b0;
      end
    end
  end

  // Present one operation and hold it until accepted; inputs are scrambled
  // afterwards so late input changes would corrupt a non-latching design.
  task automatic issue(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [AW-1:0] wd, input logic wreg, input bit push,
                       output int waited);
    exp_t e;
    @(negedge clk);
    valid_i = 1'b1; aluop_i = op; reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = wreg;
    #1;
    waited = 0;
    while (!ready_o && waited < 500) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!ready_o) begin
      check("accept_timeout", 64'(waited), 64'(0));
      valid_i = 1'b0;
      return;
    end
    if (push) begin
      e.wd = wd; e.wreg = wreg; e.data = model(op, a, b);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
    aluop_i = 4'($urandom); reg1_i = $urandom; reg2_i = $urandom;
    wd_i = 5'($urandom); wreg_i = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || valid_o) && n < 3000) begin
      @(negedge clk); n++;
    end
    if (n >= 3000) check("drain_timeout", 64'(sb.size()), 64'(0));
    @(negedge clk);
  endtask

  // Divide directed case: latency, busy duration and ready_o low throughout.
  task automatic div_case(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int w, lat, busy_cnt, rdy_seen;
    issue(op, a, b, 5'd9, 1'b1, 1'b1, w);
    lat = 0; busy_cnt = 0; rdy_seen = 0;
    while (!valid_o && lat < 100) begin
      busy_cnt += int'(busy_o);
      rdy_seen += int'(ready_o);
      @(posedge clk); #1;
      lat++;
    end
    check("div_latency", 64'(lat), 64'(33));
    check("div_busy_cycles", 64'(busy_cnt), 64'(33));
    check("div_ready_low", 64'(rdy_seen), 64'(0));
  endtask

  function automatic logic [DW-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int w, tot, seen;
    logic [3:0]    op;
    logic [DW-1:0] a, b;
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; aluop_i = '0;
    reg1_i = '0; reg2_i = '0; wd_i = '0; wreg_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("reset_outputs", 64'({valid_o, busy_o, wreg_o, wd_o, wdata_o}), 64'(0));

    // Release reset; the first edge afterwards must accept.
    @(posedge clk); #2 rst = 1'b0;
    issue(4'd0, 32'h0000_F0F0, 32'h0F0F_0000, 5'd3, 1'b1, 1'b1, w);
    check("first_accept_wait", 64'(w), 64'(0));
    check("or_latency", 64'(valid_o), 64'(1));
    check("or_value", 64'({wd_o, wreg_o, wdata_o}), 64'({5'd3, 1'b1, 32'h0F0F_F0F0}));

    drain();
    div_case(4'd11, 32'd100, 32'd7);
    drain();
    div_case(4'd12, 32'd100, 32'd7);
    drain();

    // Divide by zero is a single-cycle op.
    issue(4'd11, 32'd5, 32'd0, 5'd4, 1'b1, 1'b1, w);
    check("div0_valid", 64'({valid_o, busy_o}), 64'({1'b1, 1'b0}));
    issue(4'd12, 32'd5, 32'd0, 5'd5, 1'b0, 1'b1, w);
    check("rem0_valid", 64'({valid_o, busy_o}), 64'({1'b1, 1'b0}));

    // Boundary single-cycle ops issued back to back.
    tot = 0;
    issue(4'd10, 32'h8000_0000, 32'd31, 5'd1, 1'b1, 1'b1, w); tot += w;
    issue(4'd6,  32'hFFFF_FFFF, 32'd1,  5'd2, 1'b1, 1'b1, w); tot += w;
    issue(4'd7,  32'hFFFF_FFFF, 32'd1,  5'd3, 1'b1, 1'b1, w); tot += w;
    issue(4'd14, 32'h1234_5678, 32'd9,  5'd4, 1'b1, 1'b1, w); tot += w;
    for (int i = 0; i < 8; i++) begin
      issue(4'($urandom_range(0, 10)), $urandom, $urandom, 5'($urandom), 1'($urandom), 1'b1, w);
      tot += w;
    end
    check("b2b_stalls", 64'(tot), 64'(0));
    drain();

    // Downstream stall with ADD pending; SUB must wait for ready_i.
    rdy_force = 1'b0;
    @(negedge clk);
    issue(4'd4, 32'hFFFF_FFFF, 32'd1, 5'd7, 1'b1, 1'b1, w);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("stall_ready_low", 64'({ready_o, valid_o, wdata_o}), 64'({1'b0, 1'b1, 32'd0}));
    end
    fork
      issue(4'd5, 32'd10, 32'd3, 5'd8, 1'b0, 1'b1, w);
      begin repeat (5) @(negedge clk); rdy_force = 1'b1; end
    join
    check("sub_waited", 64'(w != 0), 64'(1));
    drain();

    // Reset in the middle of a divide.
    issue(4'd11, 32'hDEAD_BEEF, 32'd13, 5'd6, 1'b1, 1'b0, w);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("rst_mid_div", 64'({valid_o, busy_o, wreg_o, wd_o, wdata_o}), 64'(0));
    sb.delete();
    @(posedge clk); #2 rst = 1'b0;
    issue(4'd0, 32'h0000_00F0, 32'h0000_0F00, 5'd2, 1'b1, 1'b1, w);
    check("post_rst_accept_wait", 64'(w), 64'(0));
    drain();
    seen = 0;
    repeat (40) begin @(negedge clk); #1; seen += int'(valid_o); end
    check("no_stale_result", 64'(seen), 64'(0));

    // Randomized traffic with random downstream back-pressure.
    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      a = pick(); b = pick();
      if ((op == 4'd11 || op == 4'd12) && $urandom_range(0, 3) == 0) b = '0;
      issue(op, a, b, 5'($urandom), 1'($urandom), 1'b1, w);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
    end
    rdy_rand = 1'b0; rdy_force = 1'b1;
    drain();
    check("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
